sprite_mem_ctrl: RTL and testbench

Controller that shares one single-port synchronous sprite memory (64×64 texels, column-major: address = {col,row}) between two requesters. The renderer fetches texels with priority; a host port writes sprite data at runtime and optionally reads it back. A starvation guard keeps host traffic moving during continuous rendering. It sits between the pixel pipeline, the host/SPI register block, and the sprite RAM.

---
 rtl/raybox_sprite_pkg.sv | 24 ++
 rtl/sprite_ram.sv | 33 +++
 rtl/sprite_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_sprite_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raybox_sprite_pkg.sv
// Shared definitions for the sprite memory path.
// Contents: sprite address width, texel width helper, host FSM state
// type and the per-cycle grant encoding used by sprite_mem_ctrl.
package raybox_sprite_pkg;

    localparam int SPRITE_ADDR_BITS = 12;

    // Texel is three colour channels of channel_bits each.
    function automatic int texel_bits(input int channel_bits);
        return channel_bits * 3;
    endfunction

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } host_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_REND = 2'd1,
        G_HOST = 2'd2
    } grant_t;

endpackage

// File: rtl/sprite_ram.sv
// Single-port synchronous sprite RAM, 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk          - clock
//   en           - access strobe; when low the array and rdata hold
//   we           - 1 = write wdata to addr, 0 = read addr into rdata
//   addr, wdata  - access address / write data
//   rdata        - registered read data, valid the cycle after a read
// Contents power up undefined; the host port loads sprite data at runtime.
module sprite_ram #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sprite_mem_ctrl.sv
// Arbiter/controller sharing one single-port sprite RAM between the
// renderer (priority reads) and a host port (writes, optional reads).
// A starvation counter forces a host slot after STARVE_LIMIT consecutive
// denied host cycles.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   r_req/r_col/r_row           - renderer texel request
//   r_gnt                       - renderer access issued this cycle (comb)
//   r_valid/r_data              - renderer texel, one cycle after r_gnt
//   h_req/h_we/h_addr/h_wdata   - host request, held until h_ack
//   h_ack/h_rdata               - host completion pulse / read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - sprite RAM port
// Build option: define SPRITE_HOST_READ_EN to let host reads access the
// RAM and return data; otherwise host reads are acked with zero data and
// never touch the RAM.
module sprite_mem_ctrl
    import raybox_sprite_pkg::*;
#(
    parameter int CHANNEL_BITS = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 r_req,
    input  logic [5:0]                           r_col,
    input  logic [5:0]                           r_row,
    output logic                                 r_gnt,
    output logic                                 r_valid,
    output logic [texel_bits(CHANNEL_BITS)-1:0]  r_data,
    input  logic                                 h_req,
    input  logic                                 h_we,
    input  logic [SPRITE_ADDR_BITS-1:0]          h_addr,
    input  logic [texel_bits(CHANNEL_BITS)-1:0]  h_wdata,
    output logic                                 h_ack,
    output logic [texel_bits(CHANNEL_BITS)-1:0]  h_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [SPRITE_ADDR_BITS-1:0]          mem_addr,
    output logic [texel_bits(CHANNEL_BITS)-1:0]  mem_wdata,
    input  logic [texel_bits(CHANNEL_BITS)-1:0]  mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    host_state_t h_state;
    logic [7:0]  starve;
    logic        h_idle;
    logic        force_host;
    logic        hg;
    logic        rg;
    grant_t      grant;

    // Host is only eligible in H_IDLE, so a request held across its own
    // ack cycle cannot be issued twice.
    always_comb begin
        h_idle     = (h_state == H_IDLE);
        force_host = h_req && h_idle && (starve == LIMIT);
        hg         = force_host || (h_req && h_idle && !r_req);
        rg         = r_req && !force_host;
        grant      = G_NONE;
        if (rg) begin
            grant = G_REND;
        end else if (hg) begin
            grant = G_HOST;
        end
    end

    assign r_gnt = rg;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            G_REND: begin
                mem_en   = 1'b1;
                mem_addr = {r_col, r_row};
            end
            G_HOST: begin
`ifdef SPRITE_HOST_READ_EN
                mem_en    = 1'b1;
                mem_we    = h_we;
                mem_addr  = h_addr;
                mem_wdata = h_wdata;
`else
                // Reads still consume the slot and get acked, but the RAM
                // is left idle.
                if (h_we) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = h_addr;
                    mem_wdata = h_wdata;
                end
`endif
            end
            default: ;
        endcase
    end

`ifdef SPRITE_HOST_READ_EN
    logic h_read_reg;   // the access being acked was a read

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_read_reg <= 1'b0;
        end else begin
            h_read_reg <= hg && !h_we;
        end
    end

    assign h_rdata = (h_ack && h_read_reg) ? mem_rdata : '0;
`else
    assign h_rdata = '0;
`endif

    assign r_data = r_valid ? mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_state <= H_IDLE;
            starve  <= '0;
            r_valid <= 1'b0;
            h_ack   <= 1'b0;
        end else begin
            r_valid <= rg;
            h_ack   <= hg;
            case (h_state)
                H_IDLE:  if (hg) h_state <= H_ACK;
                H_ACK:   h_state <= H_IDLE;
                default: h_state <= H_IDLE;
            endcase
            if (hg) begin
                starve <= '0;
            end else if (h_req && h_idle && (starve != LIMIT)) begin
                starve <= starve + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_ctrl.sv
// Testbench for sprite_mem_ctrl with a sprite_ram attached to its memory port.
// Directed vector table, hand-written starvation/reset sequences, then
// randomized traffic checked against a cycle-level reference model.
module tb_sprite_mem_ctrl;
    import raybox_sprite_pkg::*;

    localparam int CB    = 2;
    localparam int TW    = 6;
    localparam int LIMIT = 8;
`ifdef SPRITE_HOST_READ_EN
    localparam bit HR = 1'b1;
`else
    localparam bit HR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          r_req;
    logic [5:0]    r_col, r_row;
    logic          r_gnt, r_valid;
    logic [TW-1:0] r_data;
    logic          h_req, h_we;
    logic [11:0]   h_addr;
    logic [TW-1:0] h_wdata;
    logic          h_ack;
    logic [TW-1:0] h_rdata;
    logic          mem_en, mem_we;
    logic [11:0]   mem_addr;
    logic [TW-1:0] mem_wdata, mem_rdata;

    sprite_mem_ctrl #(.CHANNEL_BITS(CB), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .r_req(r_req), .r_col(r_col), .r_row(r_row),
        .r_gnt(r_gnt), .r_valid(r_valid), .r_data(r_data),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sprite_ram #(.DATA_W(TW), .ADDR_W(12)) u_ram (
        .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
        .wdata(mem_wdata), .rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TW-1:0] shadow [4096];
    int            m_wait;      // consecutive denied eligible host cycles
    bit            m_busy;      // host was served last cycle (ack now)
    bit            exp_rv, exp_ha;
    logic [TW-1:0] exp_rd, exp_hrd;

    task automatic model_reset();
        m_wait = 0; m_busy = 0;
        exp_rv = 0; exp_ha = 0; exp_rd = '0; exp_hrd = '0;
    endtask

    task automatic model_cycle(input string tag);
        bit            elig, frc, hg, rg;
        logic [11:0]   ra;
        logic          e_en, e_we;
        logic [11:0]   e_addr;
        logic [TW-1:0] e_wd;
        @(negedge clk);
        ra   = {r_col, r_row};
        elig = h_req && !m_busy;
        frc  = elig && (m_wait >= LIMIT);
        hg   = frc || (elig && !r_req);
        rg   = r_req && !frc;
        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
        if (rg) begin
            e_en = 1; e_addr = ra;
        end else if (hg && (h_we || HR)) begin
            e_en = 1; e_we = h_we; e_addr = h_addr; e_wd = h_wdata;
        end
        chk({tag, " r_gnt"},     32'(r_gnt),     32'(rg));
        chk({tag, " mem_en"},    32'(mem_en),    32'(e_en));
        chk({tag, " mem_we"},    32'(mem_we),    32'(e_we));
        chk({tag, " mem_addr"},  32'(mem_addr),  32'(e_addr));
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(e_wd));
        chk({tag, " r_valid"},   32'(r_valid),   32'(exp_rv));
        chk({tag, " r_data"},    32'(r_data),    32'(exp_rd));
        chk({tag, " h_ack"},     32'(h_ack),     32'(exp_ha));
        chk({tag, " h_rdata"},   32'(h_rdata),   32'(exp_hrd));
        if (hg)
            $display("%s host %s addr=%03h data=%02h wait=%0d", tag,
                     h_we ? "wr" : "rd", h_addr, h_we ? h_wdata : shadow[h_addr], m_wait);
        exp_rv  = rg;
        exp_rd  = rg ? shadow[ra] : '0;
        exp_ha  = hg;
        exp_hrd = (hg && !h_we && HR) ? shadow[h_addr] : '0;
        if (hg && h_we) shadow[h_addr] = h_wdata;
        m_busy = hg;
        if (hg) m_wait = 0;
        else if (elig && m_wait < LIMIT) m_wait++;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int r_req, r_col, r_row, h_req, h_we, h_addr, h_wdata;
        int e_gnt, e_en, e_we, e_addr, e_wdata, e_rv, e_rdata, e_hack, e_hrdata;
    } vec_t;
    vec_t tbl [16];

    logic [11:0] pool [16] = '{12'h0C5, 12'hFFF, 12'h041, 12'h000, 12'h001, 12'h03F,
                               12'h040, 12'h7C0, 12'h800, 12'hFC0, 12'h0C4, 12'h123,
                               12'h456, 12'h789, 12'hABC, 12'hDEF};

    task automatic new_host();
        h_req   = 1;
        h_we    = ($urandom_range(0, 2) == 0);
        h_addr  = pool[$urandom_range(0, 15)];
        h_wdata = 6'($urandom);
    endtask

    // Holds r_req with a host write pending; returns cycles until the host slot.
    task automatic measure_starve(input logic [11:0] a, input logic [5:0] d, output int w);
        r_req = 1; r_col = 3; r_row = 5;
        h_req = 1; h_we = 1; h_addr = a; h_wdata = d;
        w = -1;
        for (int c = 0; c < LIMIT + 4 && w < 0; c++) begin
            @(negedge clk);
            if (mem_en && mem_we) w = c;
            @(posedge clk); #1;
        end
        if (w < 0) begin
            errors++; checks++;
            $display("FAIL starve timeout: host never granted within %0d cycles", LIMIT + 4);
        end
        $display("starve measure addr=%03h granted after %0d cycles", a, w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, granted, acks;
        int rp_tab [4] = '{90, 100, 50, 10};

        reset = 1; r_req = 0; r_col = 0; r_row = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        r_req = 1; r_col = 3; r_row = 5;
        @(negedge clk);
        chk("reset r_valid",  32'(r_valid),  0);
        chk("reset h_ack",    32'(h_ack),    0);
        chk("reset r_gnt",    32'(r_gnt),    1);
        chk("reset mem_addr", 32'(mem_addr), 'h0C5);
        r_req = 0; reset = 0;
        @(posedge clk); #1;

        tbl[0]  = '{0,0,0, 1,1,'h0C5,'h2A, 0,1,1,'h0C5,'h2A, 0,0,    0,0};
        tbl[1]  = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         0,0,    1,0};
        tbl[2]  = '{1,3,5, 0,0,0,0,        1,1,0,'h0C5,0,     0,0,    0,0};
        tbl[3]  = '{1,3,5, 0,0,0,0,        1,1,0,'h0C5,0,     1,'h2A, 0,0};
        tbl[4]  = '{1,3,5, 0,0,0,0,        1,1,0,'h0C5,0,     1,'h2A, 0,0};
        tbl[5]  = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         1,'h2A, 0,0};
        tbl[6]  = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         0,0,    0,0};
        tbl[7]  = '{0,0,0, 1,1,'hFFF,'h15, 0,1,1,'hFFF,'h15, 0,0,    0,0};
        tbl[8]  = '{0,0,0, 1,0,'hFFF,0,    0,0,0,0,0,         0,0,    1,0};
        tbl[9]  = '{0,0,0, 1,0,'hFFF,0,    0,HR,0,HR ? 'hFFF : 0,0, 0,0, 0,0};
        tbl[10] = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         0,0,    1,HR ? 'h15 : 0};
        tbl[11] = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         0,0,    0,0};
        tbl[12] = '{1,3,5, 1,1,'h041,'h33, 1,1,0,'h0C5,0,     0,0,    0,0};
        tbl[13] = '{0,0,0, 1,1,'h041,'h33, 0,1,1,'h041,'h33, 1,'h2A, 0,0};
        tbl[14] = '{1,1,1, 0,0,0,0,        1,1,0,'h041,0,     0,0,    1,0};
        tbl[15] = '{0,0,0, 0,0,0,0,        0,0,0,0,0,         1,'h33, 0,0};

        foreach (tbl[i]) begin
            r_req = (tbl[i].r_req != 0); r_col = 6'(tbl[i].r_col); r_row = 6'(tbl[i].r_row);
            h_req = (tbl[i].h_req != 0); h_we = (tbl[i].h_we != 0);
            h_addr = 12'(tbl[i].h_addr); h_wdata = 6'(tbl[i].h_wdata);
            @(negedge clk);
            chk($sformatf("v%0d r_gnt", i),     32'(r_gnt),     tbl[i].e_gnt);
            chk($sformatf("v%0d mem_en", i),    32'(mem_en),    tbl[i].e_en);
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),    tbl[i].e_we);
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  tbl[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), tbl[i].e_wdata);
            chk($sformatf("v%0d r_valid", i),   32'(r_valid),   tbl[i].e_rv);
            chk($sformatf("v%0d r_data", i),    32'(r_data),    tbl[i].e_rdata);
            chk($sformatf("v%0d h_ack", i),     32'(h_ack),     tbl[i].e_hack);
            chk($sformatf("v%0d h_rdata", i),   32'(h_rdata),   tbl[i].e_hrdata);
            $display("vec %0d r_req=%0d h_req=%0d h_we=%0d -> r_gnt=%0d mem_en=%0d r_valid=%0d h_ack=%0d",
                     i, r_req, h_req, h_we, r_gnt, mem_en, r_valid, h_ack);
            @(posedge clk); #1;
        end

        // Starvation under continuous renderer traffic.
        r_req = 1; r_col = 3; r_row = 5;
        h_req = 1; h_we = 1; h_addr = 12'h082; h_wdata = 6'h11;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c < 8) begin
                chk($sformatf("starve c%0d r_gnt", c), 32'(r_gnt), 1);
            end else if (c == 8) begin
                chk("starve force r_gnt",    32'(r_gnt),    0);
                chk("starve force mem_we",   32'(mem_we),   1);
                chk("starve force mem_addr", 32'(mem_addr), 'h082);
                chk("starve force r_valid",  32'(r_valid),  1);
            end else begin
                chk("starve ack h_ack",   32'(h_ack),   1);
                chk("starve ack r_valid", 32'(r_valid), 0);
                chk("starve ack r_gnt",   32'(r_gnt),   1);
            end
            @(posedge clk); #1;
        end
        $display("starvation sequence: host forced at cycle 8");
        h_req = 0;
        @(posedge clk); #1;
        measure_starve(12'h083, 6'h12, w);
        chk("starve cleared wait", 32'(w), LIMIT);
        h_req = 0; r_req = 0;
        @(posedge clk); #1;

        // Renderer gaps: host gets the first r_req=0 cycle.
        h_req = 1; h_we = 1; h_addr = 12'h084; h_wdata = 6'h13;
        granted = -1;
        for (int c = 0; c < 6 && granted < 0; c++) begin
            r_req = (c % 2 == 0);
            @(negedge clk);
            if (mem_en && mem_we) granted = c;
            @(posedge clk); #1;
        end
        chk("gap grant cycle", 32'(granted), 1);
        $display("gap sequence: host granted at cycle %0d", granted);
        h_req = 0; r_req = 0;
        @(posedge clk); #1;
        measure_starve(12'h085, 6'h14, w);
        chk("gap starve cleared wait", 32'(w), LIMIT);
        h_req = 0; r_req = 0;
        @(posedge clk); #1;

        // Async reset in the host ack cycle.
        h_req = 1; h_we = 1; h_addr = 12'h0C4; h_wdata = 6'h05;
        @(negedge clk);
        chk("rst pre hg", 32'(mem_en && mem_we), 1);
        @(posedge clk); #2;
        reset = 1; #1;
        chk("rst h_ack", 32'(h_ack), 0);
        chk("rst r_valid", 32'(r_valid), 0);
        @(negedge clk);
        reset = 0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (h_ack) begin acks++; h_req = 0; end
        end
        chk("rst reissue acks", 32'(acks), 1);
        $display("reset during ack: %0d ack(s) after release", acks);

        // Async reset in the renderer valid cycle.
        r_req = 1; r_col = 3; r_row = 5;
        @(posedge clk); #1;
        chk("rst2 pre r_valid", 32'(r_valid), 1);
        reset = 1; #1;
        chk("rst2 r_valid", 32'(r_valid), 0);
        chk("rst2 r_data",  32'(r_data),  0);
        r_req = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        model_reset();

        // Preload the address pool, then random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            h_req = 1; h_we = 1; h_addr = pool[i]; h_wdata = 6'($urandom);
            model_cycle("pre");
            h_req = 0;
            model_cycle("pre");
        end
        for (int c = 0; c < 1600; c++) begin
            logic [11:0] pick;
            r_req = ($urandom_range(0, 99) < rp_tab[(c / 200) % 4]);
            pick  = pool[$urandom_range(0, 15)];
            r_col = pick[11:6]; r_row = pick[5:0];
            if (!h_req) begin
                if ($urandom_range(0, 2) == 0) new_host();
            end else if (m_busy) begin
                if ($urandom_range(0, 1) == 0) new_host();
                else h_req = 0;
            end
            model_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
